mascota_fsm: RTL and testbench
==============================

MASCOTA_FSM -- requirements
Module: mascota_fsm

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 50000000, meaning clk cycles per time tick.
REQ-002 The block SHALL have parameter DECAY_TICKS, default 5, meaning ticks per decay step.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port senal_energia, input, 1 bit, toggle level; each transition is one energy event.
REQ-006 The block SHALL have port senal_medicina, input, 1 bit, toggle level; each transition is one medicine event.
REQ-007 The block SHALL have port senal_ultrasonido, input, 1 bit, toggle level; each transition is one play event.
REQ-008 The block SHALL have port senal_fot, input, 1 bit, level; 1 means dark.
REQ-009 The block SHALL have port senal_test_activado, input, 1 bit, level; 1 means test mode.
REQ-010 The block SHALL have port senal_btest, input, 1 bit, toggle level; each transition is one test-step event.
REQ-011 The block SHALL have port estado, output, 3 bits: NEUTRO=0, FELIZ=1, CANSADO=2, ENFERMO=3, DORMIDO=4.
REQ-012 The block SHALL have ports nivel_energia, nivel_salud and nivel_animo, each an output of 3 bits, range 0..5.
REQ-013 The block SHALL have port modo_test, output, 1 bit, high while in test mode.
REQ-014 The block SHALL have port evento_valido, output, 1 bit, a one-cycle pulse per accepted event.

Function
REQ-015 Every input SHALL pass through a 2-flop synchronizer; toggle inputs SHALL be edge-detected (XOR with the previous synchronized value), so either edge direction is one event.
REQ-016 An input transition SHALL be visible on the outputs after exactly 3 rising clk edges.
REQ-017 The tick counter SHALL count 0..TICK_CYCLES-1 and wrap; the decay counter SHALL count ticks and assert a decay step every DECAY_TICKS ticks.
REQ-018 On a decay step in normal mode:
- energia SHALL decrement, or increment if estado==DORMIDO;
- animo SHALL decrement;
- salud SHALL decrement if energia was 0 before the step.
REQ-019 Event increments SHALL be: energy event +1 energia; medicine event +2 salud; play event +1 animo.
REQ-020 Every level SHALL saturate within [0,5]; a decay step and an event on the same level in the same cycle SHALL apply both (-1 then +inc), then clamp.
REQ-021 Outside test mode, estado SHALL be registered each cycle by priority: ENFERMO (salud<=1) > DORMIDO (dark) > CANSADO (energia<=1) > FELIZ (animo>=4) > NEUTRO.
REQ-022 In test mode, all of the following SHALL hold:
- modo_test=1;
- the tick and decay counters SHALL hold;
- levels SHALL freeze;
- energy, medicine and play events SHALL be ignored (no evento_valido);
- estado SHALL show test_idx.
REQ-023 Entering test mode SHALL set test_idx=0; each test-step event SHALL advance test_idx 0->1->2->3->4->0 and pulse evento_valido.
REQ-024 Test-step events SHALL be ignored outside test mode.
REQ-025 On leaving test mode, estado SHALL resume priority derivation on the next cycle, and counters SHALL resume from their held values.
REQ-026 Simultaneous events in one cycle SHALL all be applied, with a single evento_valido pulse.

Reset
REQ-027 While reset=0 at a rising edge, the block SHALL load: energia=5, salud=5, animo=3, estado=NEUTRO, modo_test=0, test_idx=0, counters=0, evento_valido=0.
REQ-028 During reset, the synchronizers SHALL keep shifting and the edge-detect registers SHALL track them, so no spurious event follows reset release.
REQ-029 Reset asserted mid-decay or mid-test SHALL take effect at the next edge and override all events.

Structure
REQ-030 Package mascota_pkg SHALL hold the state codes, MAX_LEVEL=5 and the level width of 3.
REQ-031 Sub-module evento_toggle SHALL implement one synchronizer plus edge detector, outputting the synced level and an event pulse; it SHALL be instantiated once per input.

Verification (TICK_CYCLES=4, DECAY_TICKS=2, so a decay step every 8 cycles)
REQ-032 Reset scenario: hold reset=0 for 3 cycles with all inputs=1, then release -> levels 5/5/3, estado=0, and no evento_valido for 20 cycles.
REQ-033 Decay scenario: apply no events -> energia 4@8, 1@32 (CANSADO), 0@40; animo 0@24; salud 4@48 and 1@72 (ENFERMO).
REQ-034 Medicine scenario: with salud=4, toggle senal_medicina -> salud=5 after 3 edges, with exactly one evento_valido pulse.
REQ-035 Collision scenario: with energia=2, issue an energy event in the decay cycle -> energia stays 2.
REQ-036 Test-mode scenario: set test_activado=1 -> modo_test=1 and estado=0; 3 btest toggles -> estado=3; levels unchanged over 20 cycles; set test_activado=0 -> priority estado resumes.
REQ-037 Dark scenario: set fot=1 with energia=3 -> estado=DORMIDO; energia rises to 5 over 2 decay steps, then saturates.

Source files
------------

// File: rtl/mascota_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mascota_pkg
// Description : Shared types, level limits and the saturating level update
//               helper for the virtual-pet state machine.
// Revision    : 1.0
// ============================================================================
package mascota_pkg;

    localparam int LEVEL_W = 3;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t MAX_LEVEL       = 3'd5;
    localparam level_t RST_ENERGIA     = 3'd5;
    localparam level_t RST_SALUD       = 3'd5;
    localparam level_t RST_ANIMO       = 3'd3;
    localparam level_t LOW_THRESHOLD   = 3'd1;
    localparam level_t HAPPY_THRESHOLD = 3'd4;

    localparam logic [1:0] INC_ENERGIA = 2'd1;
    localparam logic [1:0] INC_SALUD   = 2'd2;
    localparam logic [1:0] INC_ANIMO   = 2'd1;

    localparam logic [2:0] LAST_TEST_IDX = 3'd4;

    localparam int IN_ENERGIA  = 0;
    localparam int IN_MEDICINA = 1;
    localparam int IN_ULTRA    = 2;
    localparam int IN_FOT      = 3;
    localparam int IN_TEST     = 4;
    localparam int IN_BTEST    = 5;
    localparam int NUM_INPUTS  = 6;

    typedef enum logic [2:0] {
        NEUTRO  = 3'd0,
        FELIZ   = 3'd1,
        CANSADO = 3'd2,
        ENFERMO = 3'd3,
        DORMIDO = 3'd4
    } estado_t;

    // Decrement and increment are both applied before clamping to [0, MAX_LEVEL].
    function automatic level_t apply_delta(input level_t lvl, input logic [1:0] inc,
                                           input logic dec);
        logic [LEVEL_W:0] sum;
        sum = {1'b0, lvl} + {{(LEVEL_W-1){1'b0}}, inc};
        if (dec) begin
            if (sum == '0) begin
                sum = '0;
            end else begin
                sum = sum - {{LEVEL_W{1'b0}}, 1'b1};
            end
        end
        if (sum > {1'b0, MAX_LEVEL}) begin
            sum = {1'b0, MAX_LEVEL};
        end
        return sum[LEVEL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/evento_toggle.sv
`default_nettype none
// ============================================================================
// Module      : evento_toggle
// Description : Two-flop synchronizer plus edge detector; any change of the
//               synchronized level produces a one-cycle event pulse.
// Revision    : 1.0
// ============================================================================
module evento_toggle
    import mascota_pkg::*;
(
    input  logic clk,
    input  logic async_in,
    output logic sync_level,
    output logic evento
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_prev_q;
    logic w_meta_d;
    logic w_sync_d;
    logic w_prev_d;

    always_comb begin
        w_meta_d = async_in;
        w_sync_d = r_meta_q;
        w_prev_d = r_sync_q;
    end

    // No reset: the chain keeps tracking the pin so release never sees a stale edge.
    always_ff @(posedge clk) begin
        r_meta_q <= w_meta_d;
        r_sync_q <= w_sync_d;
        r_prev_q <= w_prev_d;
    end

    assign sync_level = r_sync_q;
    assign evento     = r_sync_q ^ r_prev_q;

endmodule
`default_nettype wire

// File: rtl/mascota_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mascota_fsm
// Description : Virtual-pet controller: energy/health/mood levels with timed
//               decay, toggle-driven events, mood state and a test mode.
// Revision    : 1.0
// ============================================================================
module mascota_fsm
    import mascota_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int DECAY_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               senal_energia,
    input  logic               senal_medicina,
    input  logic               senal_ultrasonido,
    input  logic               senal_fot,
    input  logic               senal_test_activado,
    input  logic               senal_btest,
    output logic [2:0]         estado,
    output logic [LEVEL_W-1:0] nivel_energia,
    output logic [LEVEL_W-1:0] nivel_salud,
    output logic [LEVEL_W-1:0] nivel_animo,
    output logic               modo_test,
    output logic               evento_valido
);

    localparam int TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DECAY_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_sync;
    logic [NUM_INPUTS-1:0] w_evt;
    logic                  w_unused_sync;

    logic [TICK_W-1:0]  r_tick_q,  w_tick_d;
    logic [DECAY_W-1:0] r_decay_q, w_decay_d;
    level_t             r_energia_q, w_energia_d;
    level_t             r_salud_q,   w_salud_d;
    level_t             r_animo_q,   w_animo_d;
    logic [2:0]         r_test_idx_q, w_test_idx_d;
    logic               r_modo_test_q, w_modo_test_d;
    logic               r_evento_q,    w_evento_d;
    estado_t            r_estado_q,    w_estado_d;

    logic w_test_lvl;
    logic w_fot_lvl;
    logic w_decay_step;
    logic w_test_entry;
    logic w_step_ev;
    logic w_ev_e;
    logic w_ev_m;
    logic w_ev_u;
    logic w_dorm_up;

    assign w_raw[IN_ENERGIA]  = senal_energia;
    assign w_raw[IN_MEDICINA] = senal_medicina;
    assign w_raw[IN_ULTRA]    = senal_ultrasonido;
    assign w_raw[IN_FOT]      = senal_fot;
    assign w_raw[IN_TEST]     = senal_test_activado;
    assign w_raw[IN_BTEST]    = senal_btest;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_sync
            evento_toggle u_evento_toggle (
                .clk        (clk),
                .async_in   (w_raw[gi]),
                .sync_level (w_sync[gi]),
                .evento     (w_evt[gi])
            );
        end
    endgenerate

    assign w_unused_sync = ^{w_sync[IN_ENERGIA], w_sync[IN_MEDICINA], w_sync[IN_ULTRA],
                             w_sync[IN_BTEST], w_evt[IN_FOT], w_evt[IN_TEST]};

    assign w_test_lvl = w_sync[IN_TEST];
    assign w_fot_lvl  = w_sync[IN_FOT];

    // Time base: both counters freeze while test mode is active.
    always_comb begin
        w_tick_d     = r_tick_q;
        w_decay_d    = r_decay_q;
        w_decay_step = 1'b0;
        if (!w_test_lvl) begin
            if (r_tick_q == TICK_LAST) begin
                w_tick_d = '0;
                if (r_decay_q == DECAY_LAST) begin
                    w_decay_d    = '0;
                    w_decay_step = 1'b1;
                end else begin
                    w_decay_d = r_decay_q + DECAY_W'(1);
                end
            end else begin
                w_tick_d = r_tick_q + TICK_W'(1);
            end
        end
    end

    always_comb begin
        w_ev_e      = !w_test_lvl && w_evt[IN_ENERGIA];
        w_ev_m      = !w_test_lvl && w_evt[IN_MEDICINA];
        w_ev_u      = !w_test_lvl && w_evt[IN_ULTRA];
        w_dorm_up   = w_decay_step && (r_estado_q == DORMIDO);
        w_energia_d = apply_delta(r_energia_q,
                                  (w_ev_e ? INC_ENERGIA : 2'd0) + {1'b0, w_dorm_up},
                                  w_decay_step && !w_dorm_up);
        w_salud_d   = apply_delta(r_salud_q, w_ev_m ? INC_SALUD : 2'd0,
                                  w_decay_step && (r_energia_q == '0));
        w_animo_d   = apply_delta(r_animo_q, w_ev_u ? INC_ANIMO : 2'd0, w_decay_step);
    end

    always_comb begin
        w_test_entry  = w_test_lvl && !r_modo_test_q;
        w_step_ev     = 1'b0;
        w_test_idx_d  = r_test_idx_q;
        w_modo_test_d = w_test_lvl;
        if (w_test_entry) begin
            w_test_idx_d = '0;
        end else if (w_test_lvl && w_evt[IN_BTEST]) begin
            w_step_ev    = 1'b1;
            w_test_idx_d = (r_test_idx_q >= LAST_TEST_IDX) ? 3'd0 : r_test_idx_q + 3'd1;
        end
        w_evento_d = w_step_ev || w_ev_e || w_ev_m || w_ev_u;
    end

    // Next mood state is derived from the levels being written this edge.
    always_comb begin
        w_estado_d = NEUTRO;
        if (w_test_lvl) begin
            w_estado_d = estado_t'(w_test_idx_d);
        end else if (w_salud_d <= LOW_THRESHOLD) begin
            w_estado_d = ENFERMO;
        end else if (w_fot_lvl) begin
            w_estado_d = DORMIDO;
        end else if (w_energia_d <= LOW_THRESHOLD) begin
            w_estado_d = CANSADO;
        end else if (w_animo_d >= HAPPY_THRESHOLD) begin
            w_estado_d = FELIZ;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado_q <= NEUTRO;
        end else begin
            r_estado_q <= w_estado_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_q      <= '0;
            r_decay_q     <= '0;
            r_energia_q   <= RST_ENERGIA;
            r_salud_q     <= RST_SALUD;
            r_animo_q     <= RST_ANIMO;
            r_test_idx_q  <= '0;
            r_modo_test_q <= 1'b0;
            r_evento_q    <= 1'b0;
        end else begin
            r_tick_q      <= w_tick_d;
            r_decay_q     <= w_decay_d;
            r_energia_q   <= w_energia_d;
            r_salud_q     <= w_salud_d;
            r_animo_q     <= w_animo_d;
            r_test_idx_q  <= w_test_idx_d;
            r_modo_test_q <= w_modo_test_d;
            r_evento_q    <= w_evento_d;
        end
    end

    always_comb begin
        estado        = r_estado_q;
        nivel_energia = r_energia_q;
        nivel_salud   = r_salud_q;
        nivel_animo   = r_animo_q;
        modo_test     = r_modo_test_q;
        evento_valido = r_evento_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mascota_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mascota_fsm
// Description : Self-checking bench for mascota_fsm with a fast time base
//               (decay step every 8 clk cycles).
// Revision    : 1.0
// ============================================================================
module tb_mascota_fsm;

    logic       clk;
    logic       reset;
    logic       senal_energia;
    logic       senal_medicina;
    logic       senal_ultrasonido;
    logic       senal_fot;
    logic       senal_test_activado;
    logic       senal_btest;
    logic [2:0] estado;
    logic [2:0] nivel_energia;
    logic [2:0] nivel_salud;
    logic [2:0] nivel_animo;
    logic       modo_test;
    logic       evento_valido;

    mascota_fsm #(
        .TICK_CYCLES (4),
        .DECAY_TICKS (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .senal_energia       (senal_energia),
        .senal_medicina      (senal_medicina),
        .senal_ultrasonido   (senal_ultrasonido),
        .senal_fot           (senal_fot),
        .senal_test_activado (senal_test_activado),
        .senal_btest         (senal_btest),
        .estado              (estado),
        .nivel_energia       (nivel_energia),
        .nivel_salud         (nivel_salud),
        .nivel_animo         (nivel_animo),
        .modo_test           (modo_test),
        .evento_valido       (evento_valido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    due;
        string name;
        int    e;
        int    s;
        int    a;
        int    st;
        int    ev;
    } sb_t;

    typedef struct {
        string name;
        int    d;
        int    te;
        int    tm;
        int    tu;
        int    pe, ps, pa, pst;
        int    qe, qs, qa, qst;
    } ev_vec_t;

    typedef struct {
        int c;
        int e;
        int s;
        int a;
        int st;
    } dk_t;

    sb_t     sb[$];
    ev_vec_t vecs[7];
    dk_t     dk[12];

    int total;
    int passed;
    int rel;
    int ev_count;
    int mark;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, rel);
        end
    endtask

    task automatic chk_lv(input string tag, input int e, input int s, input int a, input int st);
        chk($sformatf("%s_energia", tag), int'(nivel_energia), e);
        chk($sformatf("%s_salud", tag), int'(nivel_salud), s);
        chk($sformatf("%s_animo", tag), int'(nivel_animo), a);
        chk($sformatf("%s_estado", tag), int'(estado), st);
    endtask

    task automatic score();
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == rel) begin
                chk_lv(sb[i].name, sb[i].e, sb[i].s, sb[i].a, sb[i].st);
                chk($sformatf("%s_evento", sb[i].name), int'(evento_valido), sb[i].ev);
                sb.delete(i);
            end else if (sb[i].due < rel) begin
                chk($sformatf("%s_missed", sb[i].name), rel, sb[i].due);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        rel++;
        #1;
        if (evento_valido) ev_count++;
        score();
    endtask

    task automatic run_to(input int n);
        while (rel < n) next_cycle();
    endtask

    task automatic do_reset(input logic lvl);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        senal_energia       = lvl;
        senal_medicina      = lvl;
        senal_ultrasonido   = lvl;
        senal_fot           = lvl;
        senal_test_activado = lvl;
        senal_btest         = lvl;
        reset               = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b1;
        rel   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", total);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; passed = 0; rel = 0; ev_count = 0; mark = 0;
        reset = 1'b1;
        senal_energia = 1'b0; senal_medicina = 1'b0; senal_ultrasonido = 1'b0;
        senal_fot = 1'b0; senal_test_activado = 1'b0; senal_btest = 1'b0;

        //         name              d   e  m  u  pre:e s a st  post:e s a st
        vecs[0] = '{"play",          0,  0, 0, 1, 5, 5, 3, 0,   5, 5, 4, 1};
        vecs[1] = '{"energy_sat",    0,  1, 0, 0, 5, 5, 3, 0,   5, 5, 3, 0};
        vecs[2] = '{"med_sat",       0,  0, 1, 0, 5, 5, 3, 0,   5, 5, 3, 0};
        vecs[3] = '{"all_three",     0,  1, 1, 1, 5, 5, 3, 0,   5, 5, 4, 1};
        vecs[4] = '{"play_decay",    5,  0, 0, 1, 5, 5, 3, 0,   4, 5, 3, 0};
        vecs[5] = '{"energy_decay", 29,  1, 0, 0, 2, 5, 0, 0,   2, 5, 0, 0};
        vecs[6] = '{"med_play_dec", 13,  0, 1, 1, 4, 5, 2, 0,   3, 5, 2, 0};

        dk[0]  = '{0,  5, 5, 3, 0};
        dk[1]  = '{7,  5, 5, 3, 0};
        dk[2]  = '{8,  4, 5, 2, 0};
        dk[3]  = '{16, 3, 5, 1, 0};
        dk[4]  = '{24, 2, 5, 0, 0};
        dk[5]  = '{31, 2, 5, 0, 0};
        dk[6]  = '{32, 1, 5, 0, 2};
        dk[7]  = '{40, 0, 5, 0, 2};
        dk[8]  = '{47, 0, 5, 0, 2};
        dk[9]  = '{48, 0, 4, 0, 2};
        dk[10] = '{72, 0, 1, 0, 3};
        dk[11] = '{80, 0, 0, 0, 3};

        // Reset with every input high: no events may follow release.
        do_reset(1'b1);
        chk_lv("rst", 5, 5, 3, 0);
        chk("rst_modo", int'(modo_test), 0);
        chk("rst_evento", int'(evento_valido), 0);
        mark = ev_count;
        run_to(20);
        chk("rst_pulses", ev_count - mark, 0);
        chk_lv("rst20", 5, 5, 3, 0);
        chk("rst20_modo", int'(modo_test), 1);

        // Free-running decay.
        do_reset(1'b0);
        mark = ev_count;
        for (int i = 0; i < 12; i++) begin
            run_to(dk[i].c);
            chk_lv($sformatf("decay%0d", dk[i].c), dk[i].e, dk[i].s, dk[i].a, dk[i].st);
        end
        chk("decay_pulses", ev_count - mark, 0);

        // Medicine from salud=4.
        do_reset(1'b0);
        run_to(50);
        senal_medicina = ~senal_medicina;
        mark = ev_count;
        sb.push_back('{52, "med_pre",  0, 4, 0, 2, 0});
        sb.push_back('{53, "med",      0, 5, 0, 2, 1});
        sb.push_back('{54, "med_post", 0, 5, 0, 2, 0});
        run_to(55);
        chk("med_pulses", ev_count - mark, 1);

        // Event vectors, each from a fresh reset.
        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0);
            run_to(vecs[i].d);
            if (vecs[i].te != 0) senal_energia = ~senal_energia;
            if (vecs[i].tm != 0) senal_medicina = ~senal_medicina;
            if (vecs[i].tu != 0) senal_ultrasonido = ~senal_ultrasonido;
            mark = ev_count;
            sb.push_back('{vecs[i].d + 2, $sformatf("%s_pre", vecs[i].name),
                           vecs[i].pe, vecs[i].ps, vecs[i].pa, vecs[i].pst, 0});
            sb.push_back('{vecs[i].d + 3, vecs[i].name,
                           vecs[i].qe, vecs[i].qs, vecs[i].qa, vecs[i].qst, 1});
            run_to(vecs[i].d + 6);
            chk($sformatf("%s_pulses", vecs[i].name), ev_count - mark, 1);
        end

        // Darkness: sleeping pet regains energy on decay steps.
        do_reset(1'b0);
        run_to(17);
        senal_fot = 1'b1;
        mark = ev_count;
        run_to(19); chk_lv("dark19", 3, 5, 1, 0);
        run_to(20); chk_lv("dark20", 3, 5, 1, 4);
        run_to(24); chk_lv("dark24", 4, 5, 0, 4);
        run_to(32); chk_lv("dark32", 5, 5, 0, 4);
        run_to(40); chk_lv("dark40", 5, 5, 0, 4);
        chk("dark_pulses", ev_count - mark, 0);

        // Test mode: frozen levels and counters, step index, ignored events.
        do_reset(1'b0);
        run_to(2);
        senal_test_activado = 1'b1;
        mark = ev_count;
        run_to(4); chk("test_modo4", int'(modo_test), 0);
        run_to(5); chk("test_modo5", int'(modo_test), 1);
        chk_lv("test5", 5, 5, 3, 0);
        run_to(6);  senal_btest = ~senal_btest;
        run_to(8);  senal_btest = ~senal_btest;
        run_to(9);  chk("test_idx9", int'(estado), 1);
        run_to(10); senal_btest = ~senal_btest;
        run_to(12); chk("test_idx12", int'(estado), 2);
        run_to(13); chk("test_idx13", int'(estado), 3);
        run_to(14); senal_ultrasonido = ~senal_ultrasonido;
        run_to(15); senal_energia = ~senal_energia;
        run_to(40);
        chk_lv("test40", 5, 5, 3, 3);
        chk("test_pulses", ev_count - mark, 3);
        senal_test_activado = 1'b0;
        mark = ev_count;
        run_to(42); chk("exit_modo42", int'(modo_test), 1);
        chk("exit_estado42", int'(estado), 3);
        run_to(43); chk("exit_modo43", int'(modo_test), 0);
        chk_lv("exit43", 5, 5, 3, 0);
        run_to(45); chk_lv("resume45", 5, 5, 3, 0);
        run_to(46); chk_lv("resume46", 4, 5, 2, 0);
        run_to(47); senal_btest = ~senal_btest;
        run_to(55);
        chk("btest_outside_pulses", ev_count - mark, 0);
        chk("btest_outside_estado", int'(estado), 0);

        // Reset in the middle of test mode.
        senal_test_activado = 1'b1;
        run_to(60); senal_btest = ~senal_btest;
        run_to(63); chk("midtest_idx", int'(estado), 1);
        run_to(64);
        reset = 1'b0;
        run_to(65);
        chk_lv("midtest_rst", 5, 5, 3, 0);
        chk("midtest_rst_modo", int'(modo_test), 0);
        reset = 1'b1;
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
